// File: rtl/branch_predict_ctrl.sv
// branch_predict_ctrl: bimodal 2-bit predictor with mispredict redirect, flush pulse and recovery window
module branch_predict_ctrl #(
    parameter int unsigned IDX_W        = 4,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned STAT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       if_pc,
    input  logic              if_branch,
    input  logic [31:0]       if_imm,
    output logic              predict_taken,
    output logic [31:0]       predict_target,
    input  logic              ex_valid,
    input  logic [31:0]       ex_pc,
    input  logic              ex_taken,
    input  logic              ex_pred,
    input  logic [31:0]       ex_target,
    output logic              redirect,
    output logic [31:0]       redirect_pc,
    output logic              flush,
    output logic              recovering,
    output logic [STAT_W-1:0] br_count,
    output logic [STAT_W-1:0] mispred_count
);
    localparam int unsigned N = 2 ** IDX_W;

    typedef enum logic {NORMAL, RECOVER} state_t;

    state_t            state_q;
    logic [2:0]        rcnt_q;
    logic              flush_q;
    logic [1:0]        ctr_q [N];
    logic [1:0]        ctr_d [N];
    logic [STAT_W-1:0] br_q, mis_q;
    logic [IDX_W-1:0]  if_idx, ex_idx;
    logic              normal, accept, mis;

    assign if_idx         = if_pc[IDX_W+1:2];
    assign ex_idx         = ex_pc[IDX_W+1:2];
    // gating with reset keeps the combinational outputs quiet while reset is held
    assign normal         = reset && state_q == NORMAL;
    assign accept         = ex_valid & normal;
    assign mis            = ex_taken ^ ex_pred;
    assign predict_taken  = if_branch & ctr_q[if_idx][1] & normal;
    assign predict_target = if_pc + (predict_taken ? (if_imm << 1) : 32'd4);
    assign redirect       = accept & mis;
    assign redirect_pc    = ex_taken ? ex_target : ex_pc + 32'd4;
    assign flush          = flush_q;
    assign recovering     = state_q == RECOVER;
    assign br_count       = br_q;
    assign mispred_count  = mis_q;

    // saturating train of the resolved entry; prediction reads ctr_q so no bypass
    always_comb begin
        ctr_d = ctr_q;
        if (accept)
            ctr_d[ex_idx] = ex_taken ? (ctr_q[ex_idx] == 2'd3 ? 2'd3 : ctr_q[ex_idx] + 2'd1)
                                     : (ctr_q[ex_idx] == 2'd0 ? 2'd0 : ctr_q[ex_idx] - 2'd1);
    end

    // counter table storage, weakly not-taken after reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) ctr_q[i] <= 2'b01;
        end else begin
            ctr_q <= ctr_d;
        end
    end

    // saturating branch and mispredict statistics
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            br_q  <= '0;
            mis_q <= '0;
        end else begin
            br_q  <= (accept && br_q != {STAT_W{1'b1}}) ? br_q + 1'b1 : br_q;
            mis_q <= (accept && mis && mis_q != {STAT_W{1'b1}}) ? mis_q + 1'b1 : mis_q;
        end
    end

    // recovery sequencer: a redirect pulses flush and holds RECOVER for FLUSH_CYCLES cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= NORMAL;
            rcnt_q  <= '0;
            flush_q <= 1'b0;
        end else begin
            flush_q <= accept & mis;
            if (state_q == NORMAL) begin
                if (accept && mis) begin
                    state_q <= RECOVER;
                    rcnt_q  <= 3'(FLUSH_CYCLES);
                end
            end else begin
                rcnt_q <= rcnt_q - 3'd1;
                if (rcnt_q == 3'd1) state_q <= NORMAL;
            end
        end
    end
endmodule

// File: tb/tb_branch_predict_ctrl.sv
// tb_branch_predict_ctrl: scoreboard bench for branch_predict_ctrl with a second STAT_W=2 instance
module tb_branch_predict_ctrl;
    localparam int FC = 1;

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic        t;
        logic        p;
        logic [31:0] tg;
        logic [31:0] ipc;
        logic [31:0] imm;
    } stim_t;

    typedef struct packed {
        logic        pt;
        logic [31:0] tgt;
        logic        rd;
        logic [31:0] rpc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, if_branch, ex_valid, ex_taken, ex_pred;
    logic [31:0] if_pc, if_imm, ex_pc, ex_target;
    logic        predict_taken, redirect, flush, recovering;
    logic [31:0] predict_target, redirect_pc;
    logic [15:0] br_count, mispred_count;
    logic        s_pt, s_rd, s_fl, s_rec;
    logic [31:0] s_tgt, s_rpc;
    logic [1:0]  s_br, s_mis;

    branch_predict_ctrl #(.IDX_W(4), .FLUSH_CYCLES(FC), .STAT_W(16)) dut (
        .clk(clk), .reset(reset), .if_pc(if_pc), .if_branch(if_branch), .if_imm(if_imm),
        .predict_taken(predict_taken), .predict_target(predict_target),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_pred(ex_pred),
        .ex_target(ex_target), .redirect(redirect), .redirect_pc(redirect_pc),
        .flush(flush), .recovering(recovering), .br_count(br_count), .mispred_count(mispred_count)
    );

    branch_predict_ctrl #(.IDX_W(4), .FLUSH_CYCLES(FC), .STAT_W(2)) dut_small (
        .clk(clk), .reset(reset), .if_pc(if_pc), .if_branch(if_branch), .if_imm(if_imm),
        .predict_taken(s_pt), .predict_target(s_tgt),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_pred(ex_pred),
        .ex_target(ex_target), .redirect(s_rd), .redirect_pc(s_rpc),
        .flush(s_fl), .recovering(s_rec), .br_count(s_br), .mispred_count(s_mis)
    );

    int   checks = 0, errors = 0;
    int   m_ctr [16];
    int   m_rec, m_br, m_mis;
    logic m_flush, m_acc, m_misp;
    exp_t q [$];
    exp_t e;

    task automatic do_reset();
        reset = 1'b0;
        ex_valid = 1'b0;
        for (int i = 0; i < 16; i++) m_ctr[i] = 1;
        m_rec = 0; m_br = 0; m_mis = 0; m_flush = 1'b0; m_acc = 1'b0; m_misp = 1'b0;
        q.delete();
        @(negedge clk);
        reset = 1'b1;
    endtask

    // drive one cycle of stimulus and queue what the outputs must show
    task automatic cyc(input stim_t s);
        exp_t x;
        @(negedge clk);
        ex_valid = s.v; ex_pc = s.pc; ex_taken = s.t; ex_pred = s.p; ex_target = s.tg;
        if_branch = 1'b1; if_pc = s.ipc; if_imm = s.imm;
        x.pt   = (m_ctr[s.ipc[5:2]] >= 2) && m_rec == 0;
        x.tgt  = x.pt ? s.ipc + (s.imm << 1) : s.ipc + 32'd4;
        m_acc  = s.v && m_rec == 0;
        m_misp = s.t ^ s.p;
        x.rd   = m_acc && m_misp;
        x.rpc  = s.t ? s.tg : s.pc + 32'd4;
        q.push_back(x);
        #1;
    endtask

    // advance the model across the active edge
    task automatic tick();
        int idx;
        @(posedge clk);
        if (m_acc) begin
            idx = int'(ex_pc[5:2]);
            m_ctr[idx] = ex_taken ? (m_ctr[idx] == 3 ? 3 : m_ctr[idx] + 1)
                                  : (m_ctr[idx] == 0 ? 0 : m_ctr[idx] - 1);
            m_br++;
            if (m_misp) m_mis++;
        end
        m_flush = m_acc && m_misp;
        if (m_rec > 0) m_rec--;
        if (m_acc && m_misp) m_rec = FC;
        m_acc = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; if_branch = 1'b1; if_pc = 32'h40; if_imm = 32'd8;
        ex_valid = 1'b1; ex_pc = 32'h40; ex_taken = 1'b1; ex_pred = 1'b0; ex_target = 32'h50;
        #1;
        checks++;
        if ({predict_taken, predict_target, redirect, flush, recovering, br_count, mispred_count}
            !== {1'b0, 32'h44, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0}) begin
            errors++;
            $display("FAIL reset_hold: pt=%0b tgt=%h rd=%0b fl=%0b rec=%0b br=%0d mis=%0d, want 0 00000044 0 0 0 0 0",
                     predict_taken, predict_target, redirect, flush, recovering, br_count, mispred_count);
        end
        do_reset();
        begin
            stim_t s [1];
            s[0] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h40, 32'd8};
            for (int i = 0; i < 1; i++) begin
                cyc(s[i]);
                e = q.pop_front();
                checks++;
                if ({predict_taken, predict_target, redirect, recovering, br_count, mispred_count}
                    !== {e.pt, e.tgt, e.rd, 1'b0, 16'd0, 16'd0}) begin
                    errors++;
                    $display("FAIL reset_first_fetch: pt=%0b tgt=%h rd=%0b rec=%0b br=%0d mis=%0d, want pt=%0b tgt=%h rd=%0b rec=0 br=0 mis=0",
                             predict_taken, predict_target, redirect, recovering, br_count, mispred_count, e.pt, e.tgt, e.rd);
                end
                tick();
            end
        end
    endtask

    task automatic run_table(input string name, input stim_t s [], input int n);
    endtask

    task automatic test_scenario(input string name, input stim_t s [8], input int n);
        for (int i = 0; i < n; i++) begin
            cyc(s[i]);
            e = q.pop_front();
            checks++;
            if (predict_taken !== e.pt || predict_target !== e.tgt || redirect !== e.rd ||
                s_pt !== e.pt || s_tgt !== e.tgt || s_rd !== e.rd ||
                (e.rd && (redirect_pc !== e.rpc || s_rpc !== e.rpc))) begin
                errors++;
                $display("FAIL %s[%0d] comb: pt=%0b tgt=%h rd=%0b rpc=%h, want pt=%0b tgt=%h rd=%0b rpc=%h",
                         name, i, predict_taken, predict_target, redirect, redirect_pc, e.pt, e.tgt, e.rd, e.rpc);
            end
            tick();
            checks++;
            if ({flush, recovering, br_count, mispred_count, s_fl, s_rec, s_br, s_mis}
                !== {m_flush, m_rec != 0, 16'(m_br), 16'(m_mis), m_flush, m_rec != 0,
                     (m_br > 3 ? 2'd3 : 2'(m_br)), (m_mis > 3 ? 2'd3 : 2'(m_mis))}) begin
                errors++;
                $display("FAIL %s[%0d] seq: fl=%0b rec=%0b br=%0d mis=%0d sbr=%0d smis=%0d, want fl=%0b rec=%0b br=%0d mis=%0d",
                         name, i, flush, recovering, br_count, mispred_count, s_br, s_mis,
                         m_flush, m_rec != 0, m_br, m_mis);
            end
        end
    endtask

    task automatic test_train();
        stim_t s [8];
        s[0] = '{1'b1, 32'h40, 1'b1, 1'b0, 32'h50, 32'h40, 32'd8};
        s[1] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h40, 32'd8};
        s[2] = '{1'b1, 32'h40, 1'b1, 1'b0, 32'h50, 32'h40, 32'd8};
        s[3] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h40, 32'd8};
        s[4] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h40, 32'd8};
        test_scenario("train", s, 5);
    endtask

    task automatic test_mispredict();
        stim_t s [8];
        s[0] = '{1'b1, 32'h100, 1'b0, 1'b1, 32'h200, 32'h40, 32'd8};
        s[1] = '{1'b1, 32'h40,  1'b0, 1'b1, 32'h50,  32'h40, 32'd8};
        s[2] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h40, 32'd8};
        test_scenario("mispredict", s, 3);
    endtask

    task automatic test_saturation();
        stim_t s [8];
        do_reset();
        for (int i = 0; i < 6; i++) s[i] = '{1'b1, 32'h0C, 1'b1, 1'b1, 32'h80, 32'h0C, 32'd4};
        s[6] = '{1'b1, 32'h0C, 1'b0, 1'b1, 32'h80, 32'h0C, 32'd4};
        s[7] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0C, 32'd4};
        test_scenario("saturation", s, 8);
        s[0] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0C, 32'd4};
        test_scenario("saturation_after", s, 1);
    endtask

    task automatic test_same_index();
        stim_t s [8];
        do_reset();
        s[0] = '{1'b1, 32'h14, 1'b1, 1'b1, 32'h18, 32'h14, 32'd2};
        s[1] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h14, 32'd2};
        test_scenario("same_index", s, 2);
    endtask

    task automatic test_back_to_back();
        stim_t s [8];
        s[0] = '{1'b1, 32'h20, 1'b1, 1'b0, 32'h300, 32'h24, 32'd6};
        s[1] = '{1'b1, 32'h20, 1'b1, 1'b0, 32'h300, 32'h24, 32'd6};
        s[2] = '{1'b1, 32'h20, 1'b0, 1'b1, 32'h300, 32'h24, 32'd6};
        s[3] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   32'h24, 32'd6};
        test_scenario("back_to_back", s, 4);
    endtask

    task automatic test_reset_recover();
        stim_t s [8];
        s[0] = '{1'b1, 32'h40, 1'b1, 1'b0, 32'h50, 32'h40, 32'd8};
        test_scenario("pre_reset", s, 1);
        checks++;
        if ({flush, recovering} !== 2'b11) begin
            errors++;
            $display("FAIL reset_recover_setup: fl=%0b rec=%0b, want fl=1 rec=1", flush, recovering);
        end
        #2;
        reset = 1'b0;
        ex_valid = 1'b1; ex_taken = 1'b1; ex_pred = 1'b0;
        #1;
        checks++;
        if ({flush, recovering, br_count, mispred_count, predict_taken, redirect, s_br, s_mis}
            !== {1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 2'd0, 2'd0}) begin
            errors++;
            $display("FAIL reset_recover_async: fl=%0b rec=%0b br=%0d mis=%0d pt=%0b rd=%0b, want all 0",
                     flush, recovering, br_count, mispred_count, predict_taken, redirect);
        end
        do_reset();
        s[0] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h40, 32'd8};
        test_scenario("post_reset", s, 1);
    endtask

    initial begin
        test_reset();
        test_train();
        test_mispredict();
        test_saturation();
        test_same_index();
        test_back_to_back();
        test_reset_recover();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_predict_ctrl.md
Name: branch_predict_ctrl

Overview:
- Dynamic branch-prediction controller sitting between IF and the EX-stage branch resolver.
- Holds a bimodal table of 2-bit saturating counters. Supplies a taken/not-taken prediction and target to fetch.
- Trains the table on branch resolution from EX and issues the mispredict redirect plus pipeline-flush pulse.
- Sequences a recovery window in which wrong-path resolutions are ignored. Keeps branch and mispredict statistics.

Parameters:
IDX_W, 4, table index width; table has 2**IDX_W entries
FLUSH_CYCLES, 1, cycles after a redirect during which ex_valid is ignored (1..7)
STAT_W, 16, width of the statistics counters

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
if_pc  in  32  PC of the instruction in IF
if_branch  in  1  IF instruction is a conditional branch (predecoded)
if_imm  in  32  branch immediate, halfword units
predict_taken  out  1  prediction for the IF instruction
predict_target  out  32  predicted next PC
ex_valid  in  1  a conditional branch resolves in EX this cycle
ex_pc  in  32  PC of the resolving branch
ex_taken  in  1  actual outcome
ex_pred  in  1  prediction carried down the pipe with the branch
ex_target  in  32  computed taken target (pc + imm<<1)
redirect  out  1  mispredict; IF must load redirect_pc
redirect_pc  out  32  corrected PC
flush  out  1  registered one-cycle pulse that clears IF/ID and ID/EX
recovering  out  1  high while in RECOVER
br_count  out  STAT_W  resolved branches counted
mispred_count  out  STAT_W  mispredictions counted

Behaviour:
- Reset (reset=0, asynchronous):
  - all counters := 2'b01 (weakly not-taken); FSM := NORMAL; flush=0; br_count=0; mispred_count=0.
  - Combinational outputs under reset: predict_taken=0, redirect=0.
- Index: idx = pc[IDX_W+1:2] (word-aligned PC, bits [1:0] ignored).
- Prediction (combinational, zero latency):
  - predict_taken = if_branch & ctr[if_idx][1] & (state==NORMAL).
  - predict_target = predict_taken ? if_pc + (if_imm<<1) : if_pc + 4. Addition is 32-bit and wraps modulo 2^32.
- Resolution (when accept = ex_valid & state==NORMAL):
  - mis = ex_taken ^ ex_pred.
  - redirect = accept & mis (combinational, same cycle).
  - redirect_pc = ex_taken ? ex_target : ex_pc + 4. When redirect=0, redirect_pc is don't-care but must be held stable (no X).
- Training (at the clock edge when accept=1):
  - ctr[ex_idx] += 1 if ex_taken, saturating at 3; else -= 1, saturating at 0.
  - Training happens whether or not the branch mispredicted.
- Same-index read and write in one cycle: the prediction uses the pre-update value (no bypass).
- Statistics (saturating, never wrap):
  - br_count += 1 on accept.
  - mispred_count += 1 on accept & mis.
- FSM:
  - NORMAL -> RECOVER when accept & mis. On that edge: flush := 1 for exactly one cycle; down-counter := FLUSH_CYCLES.
  - RECOVER: ex_valid ignored (no training, no redirect, no stats); predict_taken forced 0; recovering=1.
  - In RECOVER the counter decrements each cycle; at 1 the FSM -> NORMAL on the next edge. RECOVER therefore lasts exactly FLUSH_CYCLES cycles.
  - No back-to-back redirects: a second mispredict cannot be accepted until the cycle after RECOVER exits.
- flush is registered: high in the cycle after redirect, low otherwise.
- Reset asserted mid-RECOVER: immediate return to NORMAL. Counters and stats are cleared; any pending flush is dropped.
- ex_valid with ex_pc equal to if_pc in the same cycle: handled like any other same-index case (prediction uses the old value).
- No other state. Table storage is flops, sized 2*2**IDX_W bits.

Test Plan:
- Reset then if_branch=1, if_pc=0x40, if_imm=8 -> predict_taken=0, predict_target=0x44; stats=0; recovering=0.
- Two accepted resolutions at pc=0x40, ex_taken=1, ex_pred=0, each issued after RECOVER exits -> ctr[0] goes 01->10->11. First cycle: redirect=1, redirect_pc=ex_target. Next fetch of 0x40 with imm=8 -> predict_taken=1, target=0x50.
- Mispredict (ex_taken=0, ex_pred=1, ex_pc=0x100) -> redirect=1, redirect_pc=0x104; flush=1 for exactly one cycle. With FLUSH_CYCLES=1, recovering=1 for exactly one cycle. An ex_valid during RECOVER leaves the table and stats unchanged.
- Saturation: six taken resolutions at one index (ex_pred matching) -> ctr stays 3, no redirect, br_count=6, mispred_count=0. Then one not-taken -> ctr=2, prediction stays taken.
- Same-cycle IF read and EX update at index 5 (ctr 01 -> 10) -> predict_taken=0 that cycle and 1 the next. Also force STAT_W=2 with 5 accepts -> br_count holds at 3.
- Assert reset during RECOVER with flush pending -> flush=0, recovering=0, all outputs at reset values asynchronously, before the next clock edge.
